// File: rtl/fpu_issue_sequencer.sv
// Queues 8087 ESC instructions and issues them to the FPU one at a time, returning one
// result record per instruction in program order (with a completion timeout).
module fpu_issue_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [7:0]       enq_opcode,
  input  logic [7:0]       enq_modrm,
  input  logic [79:0]      enq_data,
  input  logic             flush,
  output logic [7:0]       fpu_opcode,
  output logic [7:0]       fpu_modrm,
  output logic [79:0]      fpu_data_in,
  output logic             fpu_execute,
  input  logic             fpu_ready,
  input  logic             fpu_error,
  input  logic [79:0]      fpu_data_out,
  output logic             res_valid,
  output logic [79:0]      res_data,
  output logic             res_error,
  output logic             res_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] queue_count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [95:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [7:0]        fpu_opcode_q, fpu_opcode_d, fpu_modrm_q, fpu_modrm_d;
  logic [79:0]       fpu_data_in_q, fpu_data_in_d, res_data_q, res_data_d;
  logic              res_error_q, res_error_d, res_timeout_q, res_timeout_d;
  logic              push, pop;

  assign enq_ready = (count_q < CNT_W'(DEPTH));
  // Flush drops a same-cycle enqueue and holds off the pop so nothing new is issued.
  assign push      = enq_valid && enq_ready && !flush;
  assign pop       = (state_q == StIdle) && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    fpu_opcode_d  = fpu_opcode_q;
    fpu_modrm_d   = fpu_modrm_q;
    fpu_data_in_d = fpu_data_in_q;
    res_data_d    = res_data_q;
    res_error_d   = res_error_q;
    res_timeout_d = res_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          {fpu_opcode_d, fpu_modrm_d, fpu_data_in_d} = mem_q[rd_ptr_q];
          state_d = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + TmrW'(1);
        // First WAIT cycle (timer 0) may still see the pre-execute ready level.
        if ((timer_q != '0) && fpu_ready) begin
          res_data_d    = fpu_data_out;
          res_error_d   = fpu_error;
          res_timeout_d = 1'b0;
          state_d       = StDone;
        end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
          res_data_d    = '0;
          res_error_d   = 1'b1;
          res_timeout_d = 1'b1;
          state_d       = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      fpu_opcode_q  <= '0;
      fpu_modrm_q   <= '0;
      fpu_data_in_q <= '0;
      res_data_q    <= '0;
      res_error_q   <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= {enq_opcode, enq_modrm, enq_data};
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      fpu_opcode_q  <= fpu_opcode_d;
      fpu_modrm_q   <= fpu_modrm_d;
      fpu_data_in_q <= fpu_data_in_d;
      res_data_q    <= res_data_d;
      res_error_q   <= res_error_d;
      res_timeout_q <= res_timeout_d;
    end
  end

  assign fpu_opcode  = fpu_opcode_q;
  assign fpu_modrm   = fpu_modrm_q;
  assign fpu_data_in = fpu_data_in_q;
  assign fpu_execute = (state_q == StIssue);
  assign res_valid   = (state_q == StDone);
  assign res_data    = res_data_q;
  assign res_error   = res_error_q;
  assign res_timeout = res_timeout_q;
  assign busy        = (count_q != '0) || (state_q != StIdle);
  assign queue_count = count_q;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// Scoreboard bench for fpu_issue_sequencer: directed instructions, a small FPU model and an
// in-order result monitor.
module tb_fpu_issue_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [7:0]       enq_opcode;
  logic [7:0]       enq_modrm;
  logic [79:0]      enq_data;
  logic             flush;
  logic [7:0]       fpu_opcode;
  logic [7:0]       fpu_modrm;
  logic [79:0]      fpu_data_in;
  logic             fpu_execute;
  logic             fpu_ready = 1'b1;
  logic             fpu_error = 1'b0;
  logic [79:0]      fpu_data_out = '0;
  logic             res_valid;
  logic [79:0]      res_data;
  logic             res_error;
  logic             res_timeout;
  logic             busy;
  logic [CNT_W-1:0] queue_count;

  fpu_issue_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_opcode   (enq_opcode),
    .enq_modrm    (enq_modrm),
    .enq_data     (enq_data),
    .flush        (flush),
    .fpu_opcode   (fpu_opcode),
    .fpu_modrm    (fpu_modrm),
    .fpu_data_in  (fpu_data_in),
    .fpu_execute  (fpu_execute),
    .fpu_ready    (fpu_ready),
    .fpu_error    (fpu_error),
    .fpu_data_out (fpu_data_out),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_error    (res_error),
    .res_timeout  (res_timeout),
    .busy         (busy),
    .queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [79:0] data;
    logic        err;
    logic        tmo;
  } exp_t;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  modrm;
    logic [79:0] din;
    int          lat;   // cycles from execute to ready; 0 = never ready
    logic        err;
    logic [79:0] dout;
  } plan_t;

  exp_t  exp_q [$];
  plan_t plan_q [$];
  exp_t  cur_e;
  plan_t cur_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exec_cyc = 0;
  int exec_cnt = 0;
  int acc_cyc = 0;
  int fpu_cnt = 0;
  int fpu_lat = 0;
  logic        fpu_err_n = 1'b0;
  logic [79:0] fpu_dout_n = '0;

  logic [7:0]  t2_op    [5] = '{8'hDB, 8'hD9, 8'hD9, 8'hD9, 8'hD9};
  logic [7:0]  t2_modrm [5] = '{8'hE8, 8'hE1, 8'hE0, 8'hD0, 8'hEE};
  logic [79:0] t2_dout  [5] = '{80'h3FFF_8000_0000_0000_0000, 80'h4000_C90F_DAA2_2168_C235,
                               80'hBFFF_8000_0000_0000_0000, 80'h0000_0000_0000_0000_0000,
                               80'h7FFF_C000_0000_0000_0001};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // FPU model: drops ready on execute, raises it with the planned response after lat cycles.
  always @(posedge clk) begin
    if (fpu_execute) begin
      exec_cnt  <= exec_cnt + 1;
      exec_cyc  <= cyc;
      fpu_ready <= 1'b0;
      if (plan_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got %h/%h, required no issue", fpu_opcode, fpu_modrm);
        fpu_cnt <= 0;
      end else begin
        cur_p = plan_q.pop_front();
        check("issue_order", {fpu_opcode, fpu_modrm, fpu_data_in},
              {cur_p.op, cur_p.modrm, cur_p.din});
        fpu_lat    <= cur_p.lat;
        fpu_err_n  <= cur_p.err;
        fpu_dout_n <= cur_p.dout;
        fpu_cnt    <= (cur_p.lat == 0) ? 0 : 1;
      end
    end else if (fpu_cnt != 0) begin
      if (fpu_cnt == fpu_lat - 1) begin
        fpu_ready    <= 1'b1;
        fpu_error    <= fpu_err_n;
        fpu_data_out <= fpu_dout_n;
        fpu_cnt      <= 0;
      end else begin
        fpu_cnt <= fpu_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got res_valid data %h, required no result", res_data);
      end else begin
        cur_e = exp_q.pop_front();
        check("res_data", 96'(res_data), 96'(cur_e.data));
        check("res_error", 96'(res_error), 96'(cur_e.err));
        check("res_timeout", 96'(res_timeout), 96'(cur_e.tmo));
        if (cur_e.tmo) begin
          checks++;
          if ((cyc - exec_cyc) < 17 || (cyc - exec_cyc) > 18) begin
            errors++;
            $display("FAIL timeout_latency: got %0d cycles, required 17..18", cyc - exec_cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic plan(input logic [7:0] op, input logic [7:0] m, input logic [79:0] din,
                      input int lat, input logic err, input logic [79:0] dout);
    plan_t p;
    p.op = op; p.modrm = m; p.din = din; p.lat = lat; p.err = err; p.dout = dout;
    plan_q.push_back(p);
  endtask

  task automatic expect_res(input logic [79:0] data, input logic err, input logic tmo);
    exp_t e;
    e.data = data; e.err = err; e.tmo = tmo;
    exp_q.push_back(e);
  endtask

  task automatic enq(input logic [7:0] op, input logic [7:0] m, input logic [79:0] d);
    int   guard = 0;
    logic rdy;
    enq_valid  = 1'b1;
    enq_opcode = op;
    enq_modrm  = m;
    enq_data   = d;
    do begin
      rdy     = enq_ready;
      acc_cyc = cyc;
      tick();
      guard++;
    end while (!rdy && guard < 100);
    enq_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL enq_accept: got enq_ready=0 for 100 cycles, required acceptance");
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || busy) && g < 300) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 300) begin
      errors++;
      $display("FAIL drain: got %0d results pending busy=%0b, required drained", exp_q.size(),
               busy);
    end
  endtask

  int e0;

  initial begin
    reset      = 1'b1;
    enq_valid  = 1'b0;
    enq_opcode = '0;
    enq_modrm  = '0;
    enq_data   = '0;
    flush      = 1'b0;
    tick();
    tick();
    check("rst_enq_ready", 96'(enq_ready), 96'd1);
    check("rst_busy", 96'(busy), 96'd0);
    check("rst_count", 96'(queue_count), 96'd0);
    check("rst_execute", 96'(fpu_execute), 96'd0);
    check("rst_res_flags", {res_valid, res_error, res_timeout}, 96'd0);
    check("rst_fpu_regs", {fpu_opcode, fpu_modrm, fpu_data_in}, 96'd0);
    reset = 1'b0;
    tick();

    // FLD1: execute two cycles after enqueue, ready 3 cycles later
    plan(8'hD9, 8'hE8, 80'h0, 3, 1'b0, 80'h3FFF_8000_0000_0000_0000);
    expect_res(80'h3FFF_8000_0000_0000_0000, 1'b0, 1'b0);
    e0 = exec_cnt;
    enq(8'hD9, 8'hE8, 80'h0);
    tick(); tick(); tick();
    check("exec_latency", 96'(exec_cyc - acc_cyc), 96'd2);
    wait_drain();
    check("exec_pulses", 96'(exec_cnt - e0), 96'd1);

    // Five back-to-back with a slow FPU: 1 in flight plus 4 held fills the FIFO
    for (int i = 0; i < 5; i++) begin
      plan(t2_op[i], t2_modrm[i], 80'(i + 16), 12, 1'b0, t2_dout[i]);
      expect_res(t2_dout[i], 1'b0, 1'b0);
    end
    for (int i = 0; i < 5; i++) enq(t2_op[i], t2_modrm[i], 80'(i + 16));
    check("full_count", 96'(queue_count), 96'd4);
    check("full_enq_ready", 96'(enq_ready), 96'd0);
    wait_drain();

    // Timeout, then the next queued entry still issues
    plan(8'hD9, 8'hF0, 80'h21, 0, 1'b0, 80'hDEAD);
    expect_res(80'h0, 1'b1, 1'b1);
    plan(8'hD9, 8'hE8, 80'h22, 3, 1'b0, 80'h3FFF_8000_0000_0000_0000);
    expect_res(80'h3FFF_8000_0000_0000_0000, 1'b0, 1'b0);
    enq(8'hD9, 8'hF0, 80'h21);
    enq(8'hD9, 8'hE8, 80'h22);
    wait_drain();

    // FPU error does not halt the queue
    plan(8'hDB, 8'hE8, 80'h31, 3, 1'b1, 80'hC000_A000_0000_0000_0000);
    expect_res(80'hC000_A000_0000_0000_0000, 1'b1, 1'b0);
    plan(8'hD9, 8'hE1, 80'h32, 4, 1'b0, 80'h4001_A000_0000_0000_0000);
    expect_res(80'h4001_A000_0000_0000_0000, 1'b0, 1'b0);
    enq(8'hDB, 8'hE8, 80'h31);
    enq(8'hD9, 8'hE1, 80'h32);
    wait_drain();

    // Flush during WAIT of the first of three; same-cycle enqueue is dropped
    plan(8'hD9, 8'hE8, 80'h41, 6, 1'b0, 80'h5555);
    expect_res(80'h5555, 1'b0, 1'b0);
    e0 = exec_cnt;
    enq(8'hD9, 8'hE8, 80'h41);
    enq(8'hD9, 8'hE9, 80'h42);
    enq(8'hD9, 8'hEA, 80'h43);
    check("pre_flush_count", 96'(queue_count), 96'd2);
    flush      = 1'b1;
    enq_valid  = 1'b1;
    enq_opcode = 8'hDD;
    tick();
    flush     = 1'b0;
    enq_valid = 1'b0;
    check("flush_count", 96'(queue_count), 96'd0);
    check("flush_busy_inflight", 96'(busy), 96'd1);
    wait_drain();
    repeat (8) tick();
    check("flush_exec_pulses", 96'(exec_cnt - e0), 96'd1);
    check("flush_idle", {busy, 3'(queue_count)}, 96'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty_noop", {busy, 3'(queue_count), enq_ready}, 96'd1);

    // Reset mid-WAIT abandons the instruction with no result
    plan(8'hD9, 8'hF0, 80'h51, 0, 1'b0, 80'h0);
    enq(8'hD9, 8'hF0, 80'h51);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_flags", {res_valid, fpu_execute, busy, res_error, res_timeout}, 96'd0);
    check("mid_rst_q", {enq_ready, 3'(queue_count)}, 96'h8);
    check("mid_rst_fpu_regs", {fpu_opcode, fpu_modrm, fpu_data_in}, 96'd0);
    plan_q.delete();
    repeat (10) tick();
    plan(8'hD9, 8'hE8, 80'h61, 3, 1'b0, 80'h3FFF_8000_0000_0000_0000);
    expect_res(80'h3FFF_8000_0000_0000_0000, 1'b0, 1'b0);
    enq(8'hD9, 8'hE8, 80'h61);
    wait_drain();

    repeat (3) tick();
    check("leftover_results", 96'(exp_q.size()), 96'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100000 ns, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
